// File: rtl/xorshift_stream_mux_pkg.sv
// Shared xorshift64 helpers: the state step and per-channel seed derivation.
package xorshift_pkg;

  localparam int XS_SHIFT_A = 13;
  localparam int XS_SHIFT_B = 7;
  localparam int XS_SHIFT_C = 17;

  typedef logic [63:0] xs_state_t;

  function automatic xs_state_t xs64_step(input xs_state_t x);
    xs_state_t y;
    y = x ^ (x << XS_SHIFT_A);
    y = y ^ (y >> XS_SHIFT_B);
    y = y ^ (y << XS_SHIFT_C);
    return y;
  endfunction

  // An all-zero state would lock the generator at zero, so it is remapped to 1.
  function automatic xs_state_t xs64_seed(input xs_state_t seed, input int unsigned idx);
    xs_state_t s;
    s = seed + xs_state_t'(idx);
    return (s == '0) ? xs_state_t'(1) : s;
  endfunction

endpackage

// File: rtl/xorshift_rr_arb.sv
// Combinational round-robin pick: first requester at or after ptr, ascending with wrap.
module xorshift_rr_arb #(
  parameter  int NUM_CH = 16,
  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  idx,
  output logic              any_grant
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant     = '0;
    idx       = '0;
    any_grant = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_CH);
      if (!any_grant && req[cand]) begin
        any_grant = 1'b1;
        idx       = cand;
      end
    end
    if (any_grant) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/xorshift_stream_mux.sv
// N budgeted xorshift64 generators merged round-robin onto one registered
// valid/ready stream tagged with channel and per-channel transaction index.
module xorshift_stream_mux
  import xorshift_pkg::*;
#(
  parameter  int          NUM_CH     = 16,
  parameter  int          DATA_W     = 64,
  parameter  int          CNT_W      = 32,
  parameter  int          TXN_PER_CH = 1000,
  parameter  logic [63:0] SEED       = 64'h1,
  localparam int          IDX_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              restart,
  input  logic [NUM_CH-1:0] ch_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_chan,
  output logic [CNT_W-1:0]  out_txn,
  output logic [NUM_CH-1:0] ch_done,
  output logic              done
);

  localparam logic [CNT_W-1:0] TXN_LIM = CNT_W'(TXN_PER_CH);
  localparam bit               BOUNDED = (TXN_PER_CH != 0);

  xs_state_t         state [NUM_CH];
  logic [CNT_W-1:0]  cnt   [NUM_CH];
  logic [IDX_W-1:0]  rr_ptr, win;
  logic [NUM_CH-1:0] elig, grant;
  logic              any_grant, load;

  assign elig = ch_en & ~ch_done;
  // The output register refills whenever it is empty or being drained.
  assign load = !out_valid || out_ready;

  xorshift_rr_arb #(.NUM_CH(NUM_CH)) u_arb (
    .req      (elig),
    .ptr      (rr_ptr),
    .grant    (grant),
    .idx      (win),
    .any_grant(any_grant)
  );

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state[i] <= xs64_seed(SEED, i);
        cnt[i]   <= '0;
      end
      rr_ptr    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      out_txn   <= '0;
      ch_done   <= '0;
      done      <= 1'b0;
    end else begin
      done <= BOUNDED && (&(ch_done | ~ch_en));
      if (load) begin
        out_valid <= any_grant;
        if (any_grant) begin
          out_data <= state[win][DATA_W-1:0];
          out_chan <= win;
          out_txn  <= cnt[win];
          rr_ptr   <= (win == IDX_W'(NUM_CH - 1)) ? '0 : win + 1'b1;
        end
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (load && grant[i]) begin
          state[i] <= xs64_step(state[i]);
          cnt[i]   <= cnt[i] + 1'b1;
          if (BOUNDED && (cnt[i] + 1'b1 == TXN_LIM)) ch_done[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_xorshift_stream_mux.sv
// Three differently configured instances checked against a beat-level reference model.
module tb_xorshift_stream_mux;

  logic clk = 1'b0;
  logic rst;
  logic [2:0]      restart, rdy;
  logic [2:0][3:0] en;

  wire  [2:0]       v, dn;
  wire  [2:0][63:0] d;
  wire  [2:0][1:0]  ch;
  wire  [2:0][31:0] tx;
  wire  [2:0][3:0]  chd;

  wire        c0, cd0;
  wire [31:0] d2;
  wire        c2;
  wire [3:0]  t2;
  wire [1:0]  cd2;

  always #5 clk = ~clk;

  // id0: single channel, budget 3
  xorshift_stream_mux #(.NUM_CH(1), .DATA_W(64), .CNT_W(32), .TXN_PER_CH(3), .SEED(64'h1)) u1 (
    .clk(clk), .rst(rst), .restart(restart[0]), .ch_en(en[0][0:0]),
    .out_valid(v[0]), .out_ready(rdy[0]), .out_data(d[0]), .out_chan(c0),
    .out_txn(tx[0]), .ch_done(cd0), .done(dn[0]));
  assign ch[0]  = {1'b0, c0};
  assign chd[0] = {3'b0, cd0};

  // id1: four channels, budget 6
  xorshift_stream_mux #(.NUM_CH(4), .DATA_W(64), .CNT_W(32), .TXN_PER_CH(6), .SEED(64'h1)) u4 (
    .clk(clk), .rst(rst), .restart(restart[1]), .ch_en(en[1]),
    .out_valid(v[1]), .out_ready(rdy[1]), .out_data(d[1]), .out_chan(ch[1]),
    .out_txn(tx[1]), .ch_done(chd[1]), .done(dn[1]));

  // id2: two channels, seed wrap, 32-bit data, 4-bit counter, free-running
  xorshift_stream_mux #(.NUM_CH(2), .DATA_W(32), .CNT_W(4), .TXN_PER_CH(0),
                        .SEED(64'hFFFF_FFFF_FFFF_FFFF)) u2 (
    .clk(clk), .rst(rst), .restart(restart[2]), .ch_en(en[2][1:0]),
    .out_valid(v[2]), .out_ready(rdy[2]), .out_data(d2), .out_chan(c2),
    .out_txn(t2), .ch_done(cd2), .done(dn[2]));
  assign d[2]   = {32'b0, d2};
  assign ch[2]  = {1'b0, c2};
  assign tx[2]  = {28'b0, t2};
  assign chd[2] = {2'b0, cd2};

  int          nch [3] = '{1, 4, 2};
  int          lim [3] = '{3, 6, 0};
  int          dw  [3] = '{64, 64, 32};
  int          cw  [3] = '{32, 32, 4};
  logic [63:0] sd  [3] = '{64'h1, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF};

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: generator values and accepted-beat counts per channel,
  // plus the beat expected to sit in the output register.
  logic [63:0] m_state [4];
  int          m_cnt   [4];
  int          m_ptr;
  bit          exp_v;
  int          exp_ch;
  logic [3:0]  exp_chd;
  bit          exp_dn;

  function automatic logic [63:0] xs(input logic [63:0] x);
    x = x ^ (x << 13);
    x = x ^ (x >> 7);
    x = x ^ (x << 17);
    return x;
  endfunction

  function automatic logic [63:0] dmask(input int id);
    return (dw[id] >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << dw[id]) - 64'd1);
  endfunction

  function automatic logic [31:0] tmask(input int id);
    return (cw[id] >= 32) ? 32'hFFFF_FFFF : ((32'd1 << cw[id]) - 32'd1);
  endfunction

  function automatic int pick(input int id);
    int c;
    for (int k = 0; k < nch[id]; k++) begin
      c = (m_ptr + k) % nch[id];
      if (en[id][c] && (lim[id] == 0 || m_cnt[c] < lim[id])) return c;
    end
    return -1;
  endfunction

  task automatic model_init(input int id);
    logic [63:0] s;
    for (int c = 0; c < 4; c++) begin
      s = sd[id] + 64'(c);
      m_state[c] = (s == 64'd0) ? 64'd1 : s;
      m_cnt[c]   = 0;
    end
    m_ptr   = 0;
    exp_v   = 1'b0;
    exp_ch  = -1;
    exp_chd = '0;
    exp_dn  = 1'b0;
  endtask

  // Drive ready for the next edge, advance the model, then check at the negedge.
  task automatic cycle_check(input int id, input bit r);
    bit nd;
    int issued;
    rdy[id] = r;
    nd = (lim[id] != 0);
    for (int c = 0; c < nch[id]; c++)
      if (!(exp_chd[c] || !en[id][c])) nd = 1'b0;
    if (exp_v && r) begin
      m_state[exp_ch] = xs(m_state[exp_ch]);
      m_cnt[exp_ch]++;
      m_ptr = (exp_ch + 1) % nch[id];
    end
    if (!exp_v || r) begin
      exp_ch = pick(id);
      exp_v  = (exp_ch >= 0);
    end
    exp_chd = '0;
    for (int c = 0; c < nch[id]; c++) begin
      issued = m_cnt[c] + ((exp_v && exp_ch == c) ? 1 : 0);
      exp_chd[c] = (lim[id] != 0) && (issued >= lim[id]);
    end
    exp_dn = nd;
    @(negedge clk);
    n_tests++;
    if (v[id] !== exp_v) begin
      n_fail++;
      $display("FAIL valid id%0d: got %b want %b", id, v[id], exp_v);
    end
    if (exp_v) begin
      n_tests++;
      if (ch[id] !== 2'(exp_ch) || d[id] !== (m_state[exp_ch] & dmask(id)) ||
          tx[id] !== (32'(m_cnt[exp_ch]) & tmask(id))) begin
        n_fail++;
        $display("FAIL beat id%0d: got ch=%0d data=%h txn=%0d want ch=%0d data=%h txn=%0d",
                 id, ch[id], d[id], tx[id], exp_ch, m_state[exp_ch] & dmask(id),
                 32'(m_cnt[exp_ch]) & tmask(id));
      end
    end
    n_tests++;
    if (chd[id] !== exp_chd || dn[id] !== exp_dn) begin
      n_fail++;
      $display("FAIL done id%0d: got ch_done=%b done=%b want ch_done=%b done=%b",
               id, chd[id], dn[id], exp_chd, exp_dn);
    end
  endtask

  // Restart pulse: everything must read zero the cycle after.
  task automatic start(input int id);
    restart[id] = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({v[id], d[id], ch[id], tx[id], chd[id], dn[id]} !== '0) begin
      n_fail++;
      $display("FAIL restart id%0d: got v=%b d=%h ch=%0d txn=%0d ch_done=%b done=%b want all 0",
               id, v[id], d[id], ch[id], tx[id], chd[id], dn[id]);
    end
    restart[id] = 1'b0;
    model_init(id);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    restart = '0;
    rdy = '1;
    en[0] = 4'b0001;
    en[1] = 4'b1111;
    en[2] = 4'b0011;
    repeat (3) @(negedge clk);
    for (int id = 0; id < 3; id++) begin
      n_tests++;
      if ({v[id], d[id], ch[id], tx[id], chd[id], dn[id]} !== '0) begin
        n_fail++;
        $display("FAIL reset id%0d: got v=%b d=%h ch=%0d txn=%0d ch_done=%b done=%b want all 0",
                 id, v[id], d[id], ch[id], tx[id], chd[id], dn[id]);
      end
    end
    model_init(1);
    rst = 1'b0;
    repeat (4) cycle_check(1, 1'b1);
  endtask

  task automatic test_single();
    logic [63:0] want [3];
    want[0] = 64'h1;
    want[1] = 64'h4082_2041;
    want[2] = xs(64'h4082_2041);
    en[0] = 4'b0001;
    start(0);
    for (int k = 0; k < 3; k++) begin
      cycle_check(0, 1'b1);
      n_tests++;
      if (d[0] !== want[k] || tx[0] !== 32'(k)) begin
        n_fail++;
        $display("FAIL single beat%0d: got data=%h txn=%0d want data=%h txn=%0d",
                 k, d[0], tx[0], want[k], k);
      end
    end
    repeat (4) cycle_check(0, 1'b1);
  endtask

  task automatic test_round_robin();
    en[1] = 4'b1111;
    start(1);
    for (int k = 0; k < 5; k++) begin
      cycle_check(1, 1'b1);
      n_tests++;
      if (ch[1] !== 2'(k % 4) || tx[1] !== 32'(k / 4) || (k < 4 && d[1] !== 64'(k + 1))) begin
        n_fail++;
        $display("FAIL rr beat%0d: got ch=%0d txn=%0d data=%h want ch=%0d txn=%0d",
                 k, ch[1], tx[1], d[1], k % 4, k / 4);
      end
    end
    repeat (25) cycle_check(1, 1'b1);
  endtask

  task automatic test_backpressure();
    en[1] = 4'b1111;
    start(1);
    repeat (3) cycle_check(1, 1'b1);
    repeat (5) cycle_check(1, 1'b0);
    repeat (24) cycle_check(1, 1'b1);
  endtask

  task automatic test_enable_mask();
    en[1] = 4'b0101;
    start(1);
    repeat (16) cycle_check(1, 1'b1);
    en[1] = 4'b0000;
    start(1);
    repeat (3) cycle_check(1, 1'b1);
  endtask

  task automatic test_restart_stall();
    en[1] = 4'b1111;
    start(1);
    repeat (2) cycle_check(1, 1'b1);
    cycle_check(1, 1'b0);
    start(1);
    cycle_check(1, 1'b1);
    n_tests++;
    if (ch[1] !== 2'd0 || d[1] !== 64'h1 || tx[1] !== 32'd0) begin
      n_fail++;
      $display("FAIL restart_stall: got ch=%0d data=%h txn=%0d want ch=0 data=1 txn=0",
               ch[1], d[1], tx[1]);
    end
  endtask

  task automatic test_random();
    for (int rnd = 0; rnd < 6; rnd++) begin
      en[1] = 4'($urandom_range(1, 15));
      start(1);
      for (int k = 0; k < 40; k++) begin
        if ($urandom_range(0, 15) == 0) en[1] = 4'($urandom);
        cycle_check(1, ($urandom_range(0, 9) < 7));
      end
    end
  endtask

  task automatic test_seed_wrap();
    en[2] = 4'b0011;
    start(2);
    cycle_check(2, 1'b1);
    n_tests++;
    if (d[2] !== 64'hFFFF_FFFF || ch[2] !== 2'd0) begin
      n_fail++;
      $display("FAIL seed_wrap ch0: got ch=%0d data=%h want ch=0 data=ffffffff", ch[2], d[2]);
    end
    cycle_check(2, 1'b1);
    n_tests++;
    if (d[2] !== 64'h1 || ch[2] !== 2'd1) begin
      n_fail++;
      $display("FAIL seed_wrap ch1: got ch=%0d data=%h want ch=1 data=1", ch[2], d[2]);
    end
    for (int k = 0; k < 80; k++) cycle_check(2, ($urandom_range(0, 3) != 0));
    n_tests++;
    if (dn[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL free_run_done: got %b want 0", dn[2]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_enable_mask();
    test_restart_stall();
    test_random();
    test_seed_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/xorshift_stream_mux.md
Name: xorshift_stream_mux

Overview:
- Synthesizable, parametrised successor to the per-CPU data-source model: N independent xorshift64 generators, each bounded by a per-channel transaction budget.
- Channels are merged through a round-robin arbiter onto one registered valid/ready stream tagged with channel index and transaction index.
- Sits between test stimulus/traffic sources and any consumer needing reproducible per-channel pseudo-random 64-bit data; exposes per-channel and global completion.

Parameters:
- NUM_CH, 16, number of generator channels (1..64).
- DATA_W, 64, output data width; generator state is always 64 bit; out_data = low DATA_W bits (DATA_W <= 64).
- CNT_W, 32, transaction counter width.
- TXN_PER_CH, 1000, transactions per channel; 0 = free-running (counter wraps, done never asserts).
- SEED, 64'h1, base seed; channel i seed = SEED + i (mod 2^64), a zero result replaced by 64'h1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- restart  in  1  synchronous pulse: reload seeds, clear counters, drop pending beat.
- ch_en  in  NUM_CH  per-channel enable; disabled channels are never granted.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts beat when out_valid && out_ready.
- out_data  out  DATA_W  generator value.
- out_chan  out  $clog2(NUM_CH) (min 1)  source channel.
- out_txn  out  CNT_W  per-channel transaction index of the beat (0-based).
- ch_done  out  NUM_CH  channel i issued TXN_PER_CH beats.
- done  out  1  &(ch_done | ~ch_en), registered; held 0 when TXN_PER_CH == 0.

Behaviour:
- Reset (rst=1) or restart=1 is a synchronous reload:
  - state[i] <= seed(i); cnt[i] <= 0; rr_ptr <= 0; out_valid <= 0.
  - out_data, out_chan, out_txn <= 0; ch_done <= 0; done <= 0.
  - rst has priority over restart; a beat pending during restart is discarded, not delivered.
- xorshift64 step: x ^= x<<13; x ^= x>>7; x ^= x<<17 (64-bit, shifts zero-fill).
- Eligibility: elig[i] = ch_en[i] && !ch_done[i].
- Load condition: load = !out_valid || out_ready.
  - On load with winner w: out_data <= state[w]; out_chan <= w; out_txn <= cnt[w]; out_valid <= 1; state[w] <= step(state[w]); cnt[w] <= cnt[w]+1; rr_ptr <= w+1 (wraps to 0 at NUM_CH).
  - On load with no eligible channel: out_valid <= 0.
- Arbitration: round-robin; search starts at rr_ptr, ascending with wrap; first eligible wins.
- Stall: out_valid && !out_ready holds all output fields stable; no state or counter advances.
- Throughput: one beat per cycle with out_ready tied high.
- Latency: first out_valid in the cycle after rst deasserts, provided ch_en has an eligible channel.
- First beat of channel i carries seed(i).
- Completion:
  - ch_done[i] <= 1 in the same cycle cnt[i] is updated to TXN_PER_CH; it is sticky until rst/restart.
  - done updates one cycle after ch_done.
  - If ch_en == 0, done = 1 the cycle after reset (vacuous).
- ch_en changes take effect on the next arbitration; a beat already in the output register is unaffected.
- Free-running mode (TXN_PER_CH == 0): cnt wraps 2^CNT_W-1 -> 0; ch_done and done stay 0.

Decomposition:
- Package xorshift_pkg:
  - function xs64_step(logic [63:0]) -> logic [63:0].
  - function xs64_seed(seed, idx) with zero-to-one fixup.
  - localparam XS_SHIFT_A/B/C = 13/7/17.
  - typedef xs_state_t (64 bit).
- Sub-module xorshift_rr_arb: NUM_CH request vector + rr_ptr in; one-hot grant, encoded index and any_grant out; purely combinational, pointer register stays in parent.
- Expected size: ~200-300 lines total.

Test Plan:
- NUM_CH=1, SEED=1, TXN_PER_CH=3, out_ready=1 -> beats 0x1, 0x40822041, step(0x40822041) with out_txn 0,1,2; ch_done[0]=1 after third beat; done the following cycle; out_valid low thereafter.
- NUM_CH=4, SEED=1, all enabled, out_ready=1 -> out_chan sequence 0,1,2,3,0,...; first four out_data 1,2,3,4; out_txn 0 for each of the first four, then 1.
- Backpressure: out_ready low 5 cycles mid-stream -> out_data/out_chan/out_txn constant; no beat lost or duplicated; order resumes at the next channel.
- ch_en=4'b0101, TXN_PER_CH=2 -> only channels 0,2 emit (0,2,0,2); done asserts although channels 1,3 have cnt 0.
- restart asserted while out_valid=1 and out_ready=0 -> beat dropped; next cycle out_valid=0; following beat is channel 0 with data seed(0) and out_txn 0.
- SEED=64'hFFFF_FFFF_FFFF_FFFF, NUM_CH=2 -> channel 1 seed wraps to 0 and is forced to 0x1; first beats 0xFFFF_FFFF_FFFF_FFFF then 0x1; TXN_PER_CH=0 keeps done low indefinitely.
